// File: rtl/alu_core.sv
// rtl/alu_core.sv - RV32I integer/branch-compare ALU with one registered output stage
module alu_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic [XLEN-1:0] result_d, result_q;
    logic            zero_d, zero_q;
    logic            valid_q;

    // Signed compare uses real signed operands so a-b overflow cannot flip it.
    always_comb begin
        diff  = a - b;
        shamt = b[SHW-1:0];
        lt_s  = $signed(a) < $signed(b);
        lt_u  = a < b;
        eq    = (a == b);
    end

    always_comb begin
        result_d = diff;
        unique case (alu_ctrl)
            OP_ADD:  result_d = a + b;
            OP_SUB:  result_d = diff;
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_XOR:  result_d = a ^ b;
            OP_SLL:  result_d = a << shamt;
            OP_SRL:  result_d = a >> shamt;
            OP_SRA:  result_d = $unsigned($signed(a) >>> shamt);
            OP_SLT:  result_d = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result_d = {{(XLEN-1){1'b0}}, lt_u};
            default: result_d = diff;
        endcase
    end

    // Branch ops report the taken condition instead of a zero test.
    always_comb begin
        zero_d = (result_d == '0);
        case (alu_ctrl)
            OP_BEQ:  zero_d = eq;
            OP_BNE:  zero_d = !eq;
            OP_BLT:  zero_d = lt_s;
            OP_BGE:  zero_d = !lt_s;
            OP_BLTU: zero_d = lt_u;
            OP_BGEU: zero_d = !lt_u;
            default: zero_d = (result_d == '0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed self-checking bench for alu_core
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_core #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ez);
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = op;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        check({tag, "_valid"},  {31'b0, out_valid}, 32'd1);
        check({tag, "_result"}, result,             er);
        check({tag, "_zero"},   {31'b0, zero},      {31'b0, ez});
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        alu_ctrl = 4'h0;
        a        = '0;
        b        = '0;

        // asynchronous reset mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_result", result,             32'd0);
        check("rst_zero",   {31'b0, zero},      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_valid",  {31'b0, out_valid}, 32'd0);
        check("idle_result", result,             32'd0);

        run("add1",  4'b0000, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0);
        run("add2",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        run("sub1",  4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        run("sub2",  4'b0001, 32'h87654321, 32'h12345678, 32'h7530ECA9, 1'b0);
        run("and",   4'b0010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1);
        run("or",    4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
        run("xor",   4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1);
        run("sll1",  4'b0101, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1);
        run("sll2",  4'b0101, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
        run("srl",   4'b0110, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        run("sra1",  4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        run("sra2",  4'b0111, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF, 1'b0);
        run("sra0",  4'b0111, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0);
        run("slt1",  4'b1000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        run("slt2",  4'b1000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
        run("sltu1", 4'b1001, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b1);
        run("sltu2", 4'b1001, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0);
        run("beq1",  4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        run("beq2",  4'b1010, 32'h12345678, 32'h87654321, 32'h8ACF1357, 1'b0);
        run("bne1",  4'b1011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        run("bne2",  4'b1011, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b1);
        run("blt1",  4'b1100, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        run("blt2",  4'b1100, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run("bge1",  4'b1101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        run("bge2",  4'b1101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        run("bltu",  4'b1110, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run("bgeu1", 4'b1111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        run("bgeu2", 4'b1111, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0);

        // three back-to-back ops, then a one-cycle bubble
        run("pipe1", 4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0);
        run("pipe2", 4'b0001, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1);
        run("pipe3", 4'b0100, 32'h0000FF00, 32'h00FF0000, 32'h00FFFF00, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        alu_ctrl = 4'b0000;
        a        = 32'h11111111;
        b        = 32'h22222222;
        @(posedge clk);
        #1;
        check("gap_valid",  {31'b0, out_valid}, 32'd0);
        check("gap_result", result,             32'h00FFFF00);
        check("gap_zero",   {31'b0, zero},      32'd0);

        // reset with an op in flight must not produce an output pulse
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = 4'b0000;
        a        = 32'h00000010;
        b        = 32'h00000020;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  {31'b0, out_valid}, 32'd0);
        check("mid_rst_result", result,             32'd0);
        @(posedge clk);
        #1;
        check("in_rst_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid",  {31'b0, out_valid}, 32'd0);
        check("post_rst_result", result,             32'd0);
        check("post_rst_zero",   {31'b0, zero},      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
